// File: rtl/decode_stage_pkg.sv
// Types and constants for the decode stage: fetch/decode bundles, control
// word, immediate formats and the RV64I opcodes that decode recognises.
package decode_stage_pkg;

  localparam int XLEN_DEF   = 64;
  localparam int NREG_DEF   = 32;
  localparam int PEND_W_DEF = 2;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} imm_fmt_t;

  typedef struct packed {
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       use_imm;   // srcb carries imm instead of rs2 data
  } ctl_t;

  typedef struct packed {
    logic [31:0]         raw_instr;
    logic [XLEN_DEF-1:0] pc;
  } fetch_data_t;

  // Bundle widths follow XLEN_DEF; instantiate decode_stage with matching XLEN.
  typedef struct packed {
    ctl_t                ctl;
    logic [4:0]          dst;
    logic                wen;
    logic [XLEN_DEF-1:0] srca;
    logic [XLEN_DEF-1:0] srcb;
    logic [XLEN_DEF-1:0] imm;
    logic [XLEN_DEF-1:0] pc;
  } decode_data_t;

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational RV64I immediate generator: all formats sign-extended from
// instr[31]; IMM_NONE (R-type and unknown opcodes) yields zero.
module imm_gen
  import decode_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [31:7]     instr,
  input  imm_fmt_t        fmt,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (fmt)
      IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm32 = {instr[31:12], 12'b0};
      IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = {{(XLEN-32){imm32[31]}}, imm32};

endmodule

// File: rtl/decode_stage.sv
// Registered, handshaked RV64I decode stage with a per-register pending-write
// scoreboard. Define DECODE_BYPASS_EN to forward same-cycle writeback data.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int PEND_W = PEND_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  fetch_data_t     dataF,
  output logic [4:0]      ra1,
  output logic [4:0]      ra2,
  input  logic [XLEN-1:0] rd1,
  input  logic [XLEN-1:0] rd2,
  output logic            out_valid,
  input  logic            out_ready,
  output decode_data_t    dataD,
  input  logic            flush,
  input  logic            wb_valid,
  input  logic [4:0]      wb_dst
`ifdef DECODE_BYPASS_EN
  ,
  input  logic [XLEN-1:0] wb_data
`endif
);

  localparam int SW = PEND_W + 2;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [6:0]      opcode;
  logic [4:0]      rs1, rs2, dst;
  ctl_t            ctl;
  imm_fmt_t        fmt;
  logic            use_rs1, use_rs2, writes_rd, wen;
  logic [XLEN-1:0] imm, opa, opb;
  logic            byp1, byp2, hazard, issue;
  logic            out_valid_reg;
  decode_data_t    data_reg, bundle;
  logic [NREG-1:0][PEND_W-1:0] pend_reg, pend_next;

  assign opcode = dataF.raw_instr[6:0];
  assign rs1    = dataF.raw_instr[19:15];
  assign rs2    = dataF.raw_instr[24:20];
  assign dst    = dataF.raw_instr[11:7];
  assign ra1    = rs1;
  assign ra2    = rs2;

  always_comb begin
    ctl          = '0;
    ctl.opcode   = opcode;
    ctl.funct3   = dataF.raw_instr[14:12];
    ctl.funct7b5 = dataF.raw_instr[30];
    fmt          = IMM_NONE;
    use_rs1      = 1'b0;
    use_rs2      = 1'b0;
    writes_rd    = 1'b0;
    case (opcode)
      OP_OP, OP_OP32: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; writes_rd = 1'b1;
      end
      OP_IMM, OP_IMM32, OP_LOAD, OP_JALR: begin
        fmt = IMM_I; ctl.use_imm = 1'b1; use_rs1 = 1'b1; writes_rd = 1'b1;
      end
      OP_STORE: begin
        fmt = IMM_S; use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        fmt = IMM_B; use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        fmt = IMM_U; ctl.use_imm = 1'b1; writes_rd = 1'b1;
      end
      OP_JAL: begin
        fmt = IMM_J; ctl.use_imm = 1'b1; writes_rd = 1'b1;
      end
      default: ;
    endcase
  end

  assign wen = writes_rd && (dst != 5'd0);

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (dataF.raw_instr[31:7]),
    .fmt   (fmt),
    .imm   (imm)
  );

`ifdef DECODE_BYPASS_EN
  // A count of one retiring this very cycle is the only write still in flight.
  assign byp1 = wb_valid && (wb_dst == rs1) && (pend_reg[rs1] == PEND_W'(1));
  assign byp2 = wb_valid && (wb_dst == rs2) && (pend_reg[rs2] == PEND_W'(1));
  assign opa  = byp1 ? wb_data : rd1;
  assign opb  = byp2 ? wb_data : rd2;
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
  assign opa  = rd1;
  assign opb  = rd2;
`endif

  assign hazard = (use_rs1 && (rs1 != 5'd0) && (pend_reg[rs1] != '0) && !byp1)
               || (use_rs2 && (rs2 != 5'd0) && (pend_reg[rs2] != '0) && !byp2)
               || (wen && (pend_reg[dst] == PEND_MAX));
  assign in_ready = (!out_valid_reg || out_ready) && !hazard && !flush;
  assign issue    = in_valid && in_ready;

  always_comb begin
    bundle      = '0;
    bundle.ctl  = ctl;
    bundle.dst  = dst;
    bundle.wen  = wen;
    bundle.srca = opa;
    bundle.srcb = ctl.use_imm ? imm : opb;
    bundle.imm  = imm;
    bundle.pc   = dataF.pc;
  end

  // Net update per register: +issue, -writeback, -killed bundle on flush.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_pend
      if (gi == 0) begin : g_x0
        assign pend_next[gi] = '0;
      end else begin : g_reg
        logic          inc, dec_wb, dec_fl;
        logic [SW-1:0] sum;
        assign inc    = issue && wen && (dst == 5'(gi));
        assign dec_wb = wb_valid && (wb_dst == 5'(gi));
        assign dec_fl = flush && out_valid_reg && data_reg.wen && (data_reg.dst == 5'(gi));
        assign sum    = {2'b00, pend_reg[gi]} + SW'(inc) - SW'(dec_wb) - SW'(dec_fl);
        assign pend_next[gi] = sum[SW-1] ? '0 : (sum[PEND_W] ? PEND_MAX : sum[PEND_W-1:0]);
        assert property (@(posedge clk) disable iff (reset) !sum[SW-1]);
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      data_reg      <= '0;
      pend_reg      <= '0;
    end else begin
      pend_reg <= pend_next;
      if (flush) begin
        out_valid_reg <= 1'b0;
      end else if (issue) begin
        out_valid_reg <= 1'b1;
        data_reg      <= bundle;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign dataD     = data_reg;

endmodule
